// File: rtl/lcd_pkg.sv
// Shared character constants, FSM state encodings and cell-index helper for the LCD text buffer.
package lcd_pkg;

    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_LF = 8'h0A;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CLEAR  = 2'd1;
    localparam logic [1:0] S_SCROLL = 2'd2;

    function automatic int cell_idx(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/lcd_cursor.sv
// Row/column cursor for the LCD text buffer: advance, newline, absolute load and home-to-last-row.
// last_cell / last_row tell the owner when the next move would wrap.
module lcd_cursor import lcd_pkg::*; #(
    parameter int COLS = 16,
    parameter int ROWS = 2,
    parameter int AW   = $clog2(ROWS * COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          zero,
    input  logic          home_last,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic          adv,
    input  logic          nl,
    output logic [AW-1:0] cursor,
    output logic          last_cell,
    output logic          last_row
);
    localparam int N  = ROWS * COLS;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [RW-1:0] row_inc;
    logic [RW-1:0] ld_row;
    logic [CW-1:0] ld_col;
    logic          ld_ok;
    logic          last_col;

    assign last_row  = (int'(row) == ROWS - 1);
    assign last_col  = (int'(col) == COLS - 1);
    assign last_cell = last_row && last_col;
    assign row_inc   = last_row ? '0 : row + RW'(1);

    // Out-of-range load targets park the cursor at cell 0.
    assign ld_ok  = (int'(load_addr) < N);
    assign ld_row = ld_ok ? RW'(int'(load_addr) / COLS) : '0;
    assign ld_col = ld_ok ? CW'(int'(load_addr) % COLS) : '0;

    always_ff @(posedge clk) begin
        if (rst || zero) begin
            row <= '0;
            col <= '0;
        end else if (home_last) begin
            row <= RW'(ROWS - 1);
            col <= '0;
        end else if (load) begin
            row <= ld_row;
            col <= ld_col;
        end else if (nl) begin
            row <= row_inc;
            col <= '0;
        end else if (adv) begin
            if (last_col) begin
                row <= row_inc;
                col <= '0;
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    assign cursor = AW'(cell_idx(int'(row), int'(col), COLS));

endmodule

// File: rtl/lcd_text_buffer.sv
// ROWS x COLS character buffer between game logic and the LCD driver, with dirty flag and read port.
// Define LCD_SCROLL_EN to scroll up one row instead of wrapping the cursor from the last row to cell 0.
//
//   state    | meaning
//   S_IDLE   | accepting writes, puts, cursor loads and clear requests
//   S_CLEAR  | sweeping FILL_CHAR over every cell, one per cycle
//   S_SCROLL | sweeping rows up by one, refilling the last row
module lcd_text_buffer import lcd_pkg::*; #(
    parameter int         COLS      = 16,
    parameter int         ROWS      = 2,
    parameter logic [7:0] FILL_CHAR = CH_SP,
    localparam int        N         = ROWS * COLS,
    localparam int        AW        = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          put_en,
    input  logic [7:0]    put_char,
    input  logic          cur_set,
    input  logic [AW-1:0] cur_addr,
    input  logic          clr,
    output logic          busy,
    output logic [AW-1:0] cursor,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          dirty,
    input  logic          dirty_ack
);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    logic [1:0]    state;
    logic [AW-1:0] sweep_idx;
    logic [7:0]    mem [N];

    logic idle, do_clr, do_wr, do_cur, do_put;
    logic is_lf, put_wr, put_nl, wr_ok;
    logic go_scroll, sweep_end, home_last, dirty_set;
    logic last_cell, last_row;

    function automatic logic in_range(input logic [AW-1:0] a);
        return int'(a) < N;
    endfunction

    // Same-cycle priority: clr > wr_en > cur_set > put_en; everything is dropped while sweeping.
    assign idle   = (state == S_IDLE);
    assign busy   = !idle;
    assign do_clr = idle && clr;
    assign do_wr  = idle && !clr && wr_en;
    assign do_cur = idle && !clr && !wr_en && cur_set;
    assign do_put = idle && !clr && !wr_en && !cur_set && put_en;

    assign is_lf  = (put_char == CH_LF);
    assign put_wr = do_put && !is_lf;
    assign put_nl = do_put && is_lf;
    assign wr_ok  = do_wr && in_range(wr_addr);

    assign sweep_end = !idle && (sweep_idx == LAST_IDX);
    assign home_last = sweep_end && (state == S_SCROLL);
    assign dirty_set = wr_ok || put_wr || sweep_end;

`ifdef LCD_SCROLL_EN
    localparam logic [AW-1:0] COLS_OFS = AW'(COLS);
    assign go_scroll = (put_wr && last_cell) || (put_nl && last_row);
`else
    logic unused_flags;
    assign go_scroll    = 1'b0;
    assign unused_flags = last_cell | last_row;
`endif

    lcd_cursor #(
        .COLS (COLS),
        .ROWS (ROWS),
        .AW   (AW)
    ) u_cursor (
        .clk       (clk),
        .rst       (rst),
        .zero      (do_clr),
        .home_last (home_last),
        .load      (do_cur),
        .load_addr (cur_addr),
        .adv       (put_wr && !go_scroll),
        .nl        (put_nl && !go_scroll),
        .cursor    (cursor),
        .last_cell (last_cell),
        .last_row  (last_row)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_CLEAR;
            sweep_idx <= '0;
            dirty     <= 1'b0;
            rd_data   <= 8'h00;
        end else begin
            rd_data <= in_range(rd_addr) ? mem[rd_addr] : FILL_CHAR;

            if (dirty_set) begin
                dirty <= 1'b1;
            end else if (dirty_ack) begin
                dirty <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (do_clr) begin
                        state     <= S_CLEAR;
                        sweep_idx <= '0;
                    end else if (go_scroll) begin
                        state     <= S_SCROLL;
                        sweep_idx <= '0;
                    end
                end
                S_CLEAR, S_SCROLL: begin
                    if (sweep_idx == LAST_IDX) begin
                        state     <= S_IDLE;
                        sweep_idx <= '0;
                    end else begin
                        sweep_idx <= sweep_idx + AW'(1);
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    sweep_idx <= '0;
                end
            endcase
        end
    end

    // Storage carries no reset; the post-reset clear sweep initialises it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_CLEAR) begin
                mem[sweep_idx] <= FILL_CHAR;
`ifdef LCD_SCROLL_EN
            end else if (state == S_SCROLL) begin
                mem[sweep_idx] <= (int'(sweep_idx) < N - COLS) ? mem[sweep_idx + COLS_OFS] : FILL_CHAR;
`endif
            end else if (wr_ok) begin
                mem[wr_addr] <= wr_data;
            end else if (put_wr) begin
                mem[cursor] <= put_char;
            end
        end
    end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Self-checking bench for lcd_text_buffer (default 2x16 geometry, either LCD_SCROLL_EN setting).
module tb_lcd_text_buffer;

    localparam int COLS = 16;
    localparam int ROWS = 2;
    localparam int N    = ROWS * COLS;

    logic       clk = 1'b0;
    logic       rst, wr_en, put_en, cur_set, clr, dirty_ack;
    logic       busy, dirty;
    logic [4:0] wr_addr, cur_addr, rd_addr, cursor;
    logic [7:0] wr_data, put_char, rd_data;

    always #5 clk = ~clk;

    lcd_text_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .put_en    (put_en),
        .put_char  (put_char),
        .cur_set   (cur_set),
        .cur_addr  (cur_addr),
        .clr       (clr),
        .busy      (busy),
        .cursor    (cursor),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .dirty     (dirty),
        .dirty_ack (dirty_ack)
    );

    int         tests = 0;
    int         fails = 0;
    logic [7:0] ref_mem [N];
    int         ref_cur;
    logic [7:0] exp_q [$];
    int         addr_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) ref_mem[i] = 8'h20;
        ref_cur = 0;
    endtask

    task automatic wait_idle(input string tag, output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            step();
            cycles++;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", tag, busy, cycles);
        end
    endtask

    // Scoreboard: expected byte queued when rd_addr is driven, popped when rd_data appears.
    task automatic read_all(input string tag);
        logic [7:0] e;
        int         a;
        for (int i = 0; i < N; i++) begin
            rd_addr = 5'(i);
            exp_q.push_back(ref_mem[i]);
            addr_q.push_back(i);
            step();
            e = exp_q.pop_front();
            a = addr_q.pop_front();
            tests++;
            if (rd_data !== e) begin
                fails++;
                $display("FAIL %s_m[%0d]: got %h, required %h", tag, a, rd_data, e);
            end
        end
    endtask

    task automatic put(input logic [7:0] c);
        bit wraps;
        int cyc;
        put_en = 1'b1;
        put_char = c;
        step();
        put_en = 1'b0;
        wraps = (c == 8'h0A) ? (ref_cur >= (ROWS - 1) * COLS) : (ref_cur == N - 1);
        if (c != 8'h0A) ref_mem[ref_cur] = c;
`ifdef LCD_SCROLL_EN
        if (wraps) begin
            for (int i = 0; i < N; i++) ref_mem[i] = (i < N - COLS) ? ref_mem[i + COLS] : 8'h20;
            ref_cur = (ROWS - 1) * COLS;
            wait_idle("scroll", cyc);
            tests++;
            if (cyc != N) begin
                fails++;
                $display("FAIL scroll_busy_len: got %0d cycles, required %0d", cyc, N);
            end
        end else
`endif
        if (c == 8'h0A) ref_cur = (((ref_cur / COLS) + 1) % ROWS) * COLS;
        else ref_cur = (ref_cur + 1) % N;
        if (wraps && c == 8'h00) ref_cur = 0;
    endtask

    task automatic set_cursor(input int a);
        cur_set = 1'b1;
        cur_addr = 5'(a);
        step();
        cur_set = 1'b0;
        ref_cur = a;
    endtask

    task automatic test_reset();
        int cyc;
        rst = 1'b1;
        repeat (3) step();
        tests++;
        if (busy !== 1'b1 || dirty !== 1'b0 || cursor !== 5'd0 || rd_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b dirty=%b cursor=%0d rd_data=%h, required 1 0 0 00",
                     busy, dirty, cursor, rd_data);
        end
        rst = 1'b0;
        wait_idle("reset_sweep", cyc);
        tests++;
        if (cyc != N) begin
            fails++;
            $display("FAIL reset_busy_len: got %0d cycles, required %0d", cyc, N);
        end
        tests++;
        if (dirty !== 1'b1) begin
            fails++;
            $display("FAIL reset_dirty_at_end: got %b, required 1", dirty);
        end
        model_clear();
        read_all("reset");
        dirty_ack = 1'b1;
        step();
        dirty_ack = 1'b0;
        tests++;
        if (dirty !== 1'b0) begin
            fails++;
            $display("FAIL reset_ack: dirty=%b, required 0", dirty);
        end
    endtask

    task automatic test_stream();
        string s = "Score:7";
        for (int i = 0; i < s.len(); i++) put(s[i]);
        tests++;
        if (cursor !== 5'(ref_cur)) begin
            fails++;
            $display("FAIL stream_cursor: got %0d, required %0d", cursor, ref_cur);
        end
        tests++;
        if (dirty !== 1'b1) begin
            fails++;
            $display("FAIL stream_dirty: got %b, required 1", dirty);
        end
        read_all("stream");
    endtask

    task automatic test_wrap();
        set_cursor(31);
        tests++;
        if (cursor !== 5'd31) begin
            fails++;
            $display("FAIL wrap_cur_set: got %0d, required 31", cursor);
        end
        put(8'h41);
        put(8'h42);
        tests++;
        if (cursor !== 5'(ref_cur)) begin
            fails++;
            $display("FAIL wrap_cursor: got %0d, required %0d", cursor, ref_cur);
        end
        read_all("wrap");
    endtask

    task automatic test_newline();
        set_cursor(5);
        put(8'h0A);
        tests++;
        if (cursor !== 5'(ref_cur)) begin
            fails++;
            $display("FAIL newline_row0: got %0d, required %0d", cursor, ref_cur);
        end
        put(8'h0A);
        tests++;
        if (cursor !== 5'(ref_cur)) begin
            fails++;
            $display("FAIL newline_last_row: got %0d, required %0d", cursor, ref_cur);
        end
        read_all("newline");
    endtask

    task automatic test_priority();
        int cur_before;
        set_cursor(9);
        cur_before = ref_cur;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'h58;
        put_en = 1'b1; put_char = 8'h59;
        step();
        wr_en = 1'b0; put_en = 1'b0;
        ref_mem[5] = 8'h58;
        tests++;
        if (cursor !== 5'(cur_before)) begin
            fails++;
            $display("FAIL prio_wr_put_cursor: got %0d, required %0d", cursor, cur_before);
        end
        cur_set = 1'b1; cur_addr = 5'd3;
        put_en = 1'b1; put_char = 8'h5A;
        step();
        cur_set = 1'b0; put_en = 1'b0;
        ref_cur = 3;
        tests++;
        if (cursor !== 5'd3) begin
            fails++;
            $display("FAIL prio_cur_put_cursor: got %0d, required 3", cursor);
        end
        read_all("priority");
    endtask

    task automatic test_dirty();
        dirty_ack = 1'b1;
        step();
        dirty_ack = 1'b0;
        tests++;
        if (dirty !== 1'b0) begin
            fails++;
            $display("FAIL dirty_ack_alone: got %b, required 0", dirty);
        end
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 8'h44;
        dirty_ack = 1'b1;
        step();
        wr_en = 1'b0;
        ref_mem[20] = 8'h44;
        tests++;
        if (dirty !== 1'b1) begin
            fails++;
            $display("FAIL dirty_set_wins: got %b, required 1", dirty);
        end
        step();
        dirty_ack = 1'b0;
        tests++;
        if (dirty !== 1'b0) begin
            fails++;
            $display("FAIL dirty_ack_next: got %b, required 0", dirty);
        end
    endtask

    task automatic test_read_collision();
        logic [7:0] e;
        rd_addr = 5'd9;
        exp_q.push_back(ref_mem[9]);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 8'h51;
        step();
        wr_en = 1'b0;
        ref_mem[9] = 8'h51;
        e = exp_q.pop_front();
        tests++;
        if (rd_data !== e) begin
            fails++;
            $display("FAIL read_collision_old: got %h, required %h", rd_data, e);
        end
        exp_q.push_back(ref_mem[9]);
        step();
        e = exp_q.pop_front();
        tests++;
        if (rd_data !== e) begin
            fails++;
            $display("FAIL read_collision_new: got %h, required %h", rd_data, e);
        end
    endtask

    task automatic test_busy_drop();
        int cyc;
        clr = 1'b1;
        step();
        clr = 1'b0;
        model_clear();
        tests++;
        if (busy !== 1'b1 || cursor !== 5'd0) begin
            fails++;
            $display("FAIL clr_start: busy=%b cursor=%0d, required 1 0", busy, cursor);
        end
        repeat (4) step();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 8'h57;
        step();
        wr_en = 1'b0;
        put_en = 1'b1; put_char = 8'h50;
        step();
        put_en = 1'b0;
        cur_set = 1'b1; cur_addr = 5'd7;
        step();
        cur_set = 1'b0;
        wait_idle("clr_sweep", cyc);
        tests++;
        if (cyc + 7 != N) begin
            fails++;
            $display("FAIL clr_busy_len: got %0d cycles, required %0d", cyc + 7, N);
        end
        tests++;
        if (cursor !== 5'd0 || dirty !== 1'b1) begin
            fails++;
            $display("FAIL clr_end: cursor=%0d dirty=%b, required 0 1", cursor, dirty);
        end
        read_all("busy_drop");
    endtask

    task automatic test_reset_mid_sweep();
        int cyc;
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        tests++;
        if (busy !== 1'b1 || dirty !== 1'b0) begin
            fails++;
            $display("FAIL midsweep_reset: busy=%b dirty=%b, required 1 0", busy, dirty);
        end
        wait_idle("midsweep", cyc);
        tests++;
        if (cyc != N) begin
            fails++;
            $display("FAIL midsweep_busy_len: got %0d cycles, required %0d", cyc, N);
        end
        model_clear();
        read_all("midsweep");
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; put_en = 1'b0; cur_set = 1'b0; clr = 1'b0; dirty_ack = 1'b0;
        wr_addr = '0; wr_data = '0; put_char = '0; cur_addr = '0; rd_addr = '0;
        ref_cur = 0;
        test_reset();
        test_stream();
        test_wrap();
        test_newline();
        test_priority();
        test_dirty();
        test_read_collision();
        test_busy_drop();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 500000 time units");
        $fatal(1);
    end

endmodule
